// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives the request side, slave is the subtractor itself.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, ovf, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, ovf, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock; result after WIDTH SHIFT cycles,
// done pulses one cycle. No backpressure: start is simply ignored while busy.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic               br_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               a_msb_q, b_msb_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q, ovf_q, busy_q, done_q;
  logic               busy_d, done_d;

  logic               accept;
  logic               last;
  logic               bit_d;
  logic               br_nxt;
  logic [WIDTH-1:0]   res_nxt;

  assign accept  = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last    = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs of the shifting operands.
  assign bit_d   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_nxt = {bit_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        br_q    <= bus.bin;
        res_q   <= '0;
        cnt_q   <= '0;
        a_msb_q <= bus.a[WIDTH-1];
        b_msb_q <= bus.b[WIDTH-1];
      end else if (state_q == SHIFT) begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        br_q  <= br_nxt;
        res_q <= res_nxt;
        cnt_q <= cnt_q + CNT_W'(1);
        // Operand MSBs are kept aside because the shift registers lose them.
        if (last) begin
          diff_q <= res_nxt;
          bout_q <= br_nxt;
          ovf_q  <= (a_msb_q != b_msb_q) && (res_nxt[WIDTH-1] != a_msb_q);
        end
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and randomized operations at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus8  ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int checks = 0;
  int errors = 0;
  bit sel16  = 1'b0;

  logic [31:0] diff_m;
  logic        bout_m, ovf_m, busy_m, done_m;
  assign diff_m = sel16 ? 32'(bus16.diff) : 32'(bus8.diff);
  assign bout_m = sel16 ? bus16.bout : bus8.bout;
  assign ovf_m  = sel16 ? bus16.ovf  : bus8.ovf;
  assign busy_m = sel16 ? bus16.busy : bus8.busy;
  assign done_m = sel16 ? bus16.done : bus8.done;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t tbl[6];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int cur_w();
    return sel16 ? 16 : 8;
  endfunction

  // Plain arithmetic reference: unsigned difference, borrow by comparison.
  function automatic void model(int w, logic [31:0] a, logic [31:0] b, logic bin,
                                output logic [31:0] d, output logic bo, output logic ov);
    longint mask, ua, ub, r;
    mask = (64'sd1 <<< w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    r    = ua - ub - longint'(bin);
    d    = 32'(r & mask);
    bo   = (ua < ub + longint'(bin));
    ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
  endfunction

  task automatic set_in(logic st, logic [31:0] a, logic [31:0] b, logic bin);
    if (sel16) begin
      bus16.start = st; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.bin = bin;
    end else begin
      bus8.start = st; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.bin = bin;
    end
  endtask

  // Accepting edge, then operands are scrambled so late changes must not matter.
  task automatic start_op(logic [31:0] a, logic [31:0] b, logic bin);
    @(negedge clk);
    set_in(1'b1, a, b, bin);
    @(posedge clk); #1;
    set_in(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_done(output int busy_cycles, output logic got);
    busy_cycles = 0;
    for (int i = 0; i < 100 && !done_m; i++) begin
      if (busy_m) busy_cycles++;
      @(posedge clk); #1;
    end
    got = done_m;
  endtask

  task automatic run_op(string name, logic [31:0] a, logic [31:0] b, logic bin,
                        logic [31:0] ed, logic ebo, logic eov);
    int   bc;
    logic got;
    start_op(a, b, bin);
    wait_done(bc, got);
    check({name, "_done"}, 32'(got), 32'd1);
    check({name, "_busy_cycles"}, 32'(bc), 32'(cur_w()));
    check({name, "_busy_in_done"}, 32'(busy_m), 32'd0);
    check({name, "_diff"}, diff_m, ed);
    check({name, "_bout"}, 32'(bout_m), 32'(ebo));
    check({name, "_ovf"}, 32'(ovf_m), 32'(eov));
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, 32'(done_m), 32'd0);
  endtask

  task automatic count_done(int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done_m) pulses++;
    end
  endtask

  initial begin
    int          bc, pulses;
    logic        got;
    logic [31:0] ra, rb, ed;
    logic        rbin, ebo, eov;

    tbl[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    sel16 = 1'b1; set_in(1'b0, 32'h0, 32'h0, 1'b0);
    sel16 = 1'b0; set_in(1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_diff", diff_m, 32'h0);
    check("rst_bout", 32'(bout_m), 32'd0);
    check("rst_ovf",  32'(ovf_m),  32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), 32'(tbl[i].a), 32'(tbl[i].b), tbl[i].bin,
             32'(tbl[i].d), tbl[i].bo, tbl[i].ov);

    // Start re-asserted in the 3rd SHIFT cycle must be ignored.
    start_op(32'h5A, 32'h23, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    set_in(1'b1, 32'hFF, 32'h00, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 32'hFF, 32'h00, 1'b0);
    wait_done(bc, got);
    check("ign_done", 32'(got), 32'd1);
    check("ign_diff", diff_m, 32'h37);
    check("ign_bout", 32'(bout_m), 32'd0);
    count_done(12, pulses);
    check("ign_no_second_done", 32'(pulses), 32'd0);

    // Back-to-back: start held in the DONE cycle.
    start_op(32'h5A, 32'h23, 1'b0);
    wait_done(bc, got);
    check("b2b_first_done", 32'(got), 32'd1);
    set_in(1'b1, 32'h09, 32'h04, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 32'hAA, 32'h55, 1'b1);
    check("b2b_busy_again", 32'(busy_m), 32'd1);
    check("b2b_done_low", 32'(done_m), 32'd0);
    check("b2b_diff_held", diff_m, 32'h37);
    wait_done(bc, got);
    check("b2b_second_done", 32'(got), 32'd1);
    check("b2b_busy_cycles", 32'(bc), 32'd8);
    check("b2b_diff", diff_m, 32'h05);
    check("b2b_bout", 32'(bout_m), 32'd0);
    @(posedge clk); #1;

    // Reset in the 4th SHIFT cycle aborts the operation.
    start_op(32'h5A, 32'h23, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy_m), 32'd0);
    check("abort_done", 32'(done_m), 32'd0);
    check("abort_diff", diff_m, 32'h0);
    count_done(12, pulses);
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_idle_busy", 32'(busy_m), 32'd0);
    run_op("after_abort", 32'h5A, 32'h23, 1'b0, 32'h37, 1'b0, 1'b0);

    // Start coincident with reset is discarded.
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b1, 32'h80, 32'h01, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    check("rst_start_busy", 32'(busy_m), 32'd0);
    count_done(12, pulses);
    check("rst_start_no_done", 32'(pulses), 32'd0);

    for (int s = 0; s < 2; s++) begin
      sel16 = (s == 1);
      for (int i = 0; i < 1000; i++) begin
        ra   = $urandom;
        rb   = $urandom;
        rbin = 1'($urandom_range(0, 1));
        if (i == 0) begin ra = 32'h0; rb = 32'hFFFF_FFFF; rbin = 1'b1; end
        model(cur_w(), ra, rb, rbin, ed, ebo, eov);
        run_op($sformatf("rnd_w%0d_%0d", cur_w(), i), ra, rb, rbin, ed, ebo, eov);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
